// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - payload handshake and serial line bundle for serial_tx
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] D;
  logic              V;
  logic              RDY;
  logic              TX;
  logic              BUSY;

  modport master (output D, output V, input RDY, input TX, input BUSY);
  modport slave  (input D, input V, output RDY, output TX, output BUSY);
endinterface

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - bit-serial UART-style transmitter, LSB first, registered outputs
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0
) (
  input  logic        C,
  input  logic        R,
  serial_tx_if.slave  bus
);

  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int BIT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              baud_last;

  // With CLKS_PER_BIT=1 the counter stays 0 and every cycle is a bit boundary
  assign baud_last = (baud_q == BAUD_LAST);

  // Next state, counters, shifter and the value TX shows after the coming edge
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;

    if (state_q != S_IDLE) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (bus.V && rdy_q) begin
          shift_d = bus.D;
          par_d   = ^bus.D;
          state_d = S_START;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end
      end

      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.TX   = tx_q;
  assign bus.RDY  = rdy_q;
  assign bus.BUSY = busy_q;

endmodule
